// File: rtl/window_gen_3x3.sv
// Sliding 3x3 window generator: two line buffers plus a 3x3 shift window, fully registered outputs.
// Optional end-of-frame strobe Frame_Done is built only when WG_FRAME_DONE_EN is defined.
module window_gen_3x3 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDHT-1:0] Data_Out0,
  output logic [DATA_WIDHT-1:0] Data_Out1,
  output logic [DATA_WIDHT-1:0] Data_Out2,
  output logic [DATA_WIDHT-1:0] Data_Out3,
  output logic [DATA_WIDHT-1:0] Data_Out4,
  output logic [DATA_WIDHT-1:0] Data_Out5,
  output logic [DATA_WIDHT-1:0] Data_Out6,
  output logic [DATA_WIDHT-1:0] Data_Out7,
  output logic [DATA_WIDHT-1:0] Data_Out8,
  output logic                  Valid_Out
`ifdef WG_FRAME_DONE_EN
  ,
  output logic                  Frame_Done
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDHT-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDHT-1:0] lb2 [IMG_WIDTH];
  logic [DATA_WIDHT-1:0] win [9];
  logic                  last_col;
  logic                  window_ok;

  assign last_col  = (col == COL_LAST);
  assign window_ok = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (Valid_In) begin
      if (last_col) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // NOTE: the line buffers carry no reset so they map onto RAM; stale rows are masked by the row counter.
  always_ff @(posedge clk) begin
    if (Valid_In) begin
      lb2[col] <= lb1[col];
      lb1[col] <= Data_In;
    end
  end

  // Window shifts left; column 2 takes rows r-2, r-1 and r at column c.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (Valid_In) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb2[col];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[col];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= Data_In;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) Valid_Out <= 1'b0;
    else      Valid_Out <= Valid_In && window_ok;
  end

`ifdef WG_FRAME_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) Frame_Done <= 1'b0;
    else      Frame_Done <= Valid_In && last_col && (row == ROW_LAST);
  end
`endif

  assign Data_Out0 = win[0];
  assign Data_Out1 = win[1];
  assign Data_Out2 = win[2];
  assign Data_Out3 = win[3];
  assign Data_Out4 = win[4];
  assign Data_Out5 = win[5];
  assign Data_Out6 = win[6];
  assign Data_Out7 = win[7];
  assign Data_Out8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 image: scenario table plus a mid-frame reset sequence.
// Frame_Done checks are active when WG_FRAME_DONE_EN is defined.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  typedef logic [8:0][31:0] win_t;

  typedef struct packed {
    int   gap;
    int   frames;
    int   pulses;
    int   mark_idx;
    win_t mark_win;
    win_t last_win;
  } scen_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Data_In = '0;
  logic        Valid_In = 1'b0;
  logic [31:0] Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4;
  logic [31:0] Data_Out5, Data_Out6, Data_Out7, Data_Out8;
  logic        Valid_Out;
`ifdef WG_FRAME_DONE_EN
  logic        Frame_Done;
`endif

  window_gen_3x3 #(.DATA_WIDHT(32), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Data_Out0 (Data_Out0),
    .Data_Out1 (Data_Out1),
    .Data_Out2 (Data_Out2),
    .Data_Out3 (Data_Out3),
    .Data_Out4 (Data_Out4),
    .Data_Out5 (Data_Out5),
    .Data_Out6 (Data_Out6),
    .Data_Out7 (Data_Out7),
    .Data_Out8 (Data_Out8),
    .Valid_Out (Valid_Out)
`ifdef WG_FRAME_DONE_EN
    ,
    .Frame_Done(Frame_Done)
`endif
  );

  always #5 clk = ~clk;

  win_t dout;
  assign dout = {Data_Out8, Data_Out7, Data_Out6, Data_Out5, Data_Out4,
                 Data_Out3, Data_Out2, Data_Out1, Data_Out0};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the image as written so far and the raster position.
  logic [31:0] img [H][W];
  int          m_row = 0;
  int          m_col = 0;
  logic        exp_fire = 1'b0;
  logic        exp_fd = 1'b0;
  win_t        exp_q[$];
  win_t        seen[$];
  int          fd_count = 0;

  task automatic beat(input logic [31:0] d);
    win_t w;
    img[m_row][m_col] = d;
    exp_fire = (m_row >= 2) && (m_col >= 2);
    exp_fd   = (m_row == H - 1) && (m_col == W - 1);
    if (exp_fire) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r*3+c] = img[m_row-2+r][m_col-2+c];
      exp_q.push_back(w);
    end
    Valid_In = 1'b1;
    Data_In  = d;
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    @(posedge clk); #1;
    Valid_In = 1'b0;
    exp_fire = 1'b0;
    exp_fd   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every cycle outside reset, Valid_Out must follow the previous beat's expectation,
  // data must match the scoreboard on a valid window and hold when no beat was accepted.
  logic prev_vin = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_fire = 1'b0;
  logic prev_fd = 1'b0;
  win_t prev_dout = '0;

  always @(negedge clk) begin
    if (rst && prev_rst) begin
      check("valid_out_timing", 288'(Valid_Out), 288'(prev_fire));
      if (Valid_Out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", 288'(1), 288'(0));
        end else begin
          check("window_data", dout, exp_q.pop_front());
        end
        seen.push_back(dout);
      end
      if (!prev_vin) check("hold_when_idle", dout, prev_dout);
`ifdef WG_FRAME_DONE_EN
      check("frame_done_timing", 288'(Frame_Done), 288'(prev_fd));
      if (Frame_Done) fd_count++;
`endif
    end
    prev_vin  = Valid_In;
    prev_rst  = rst;
    prev_fire = exp_fire;
    prev_fd   = exp_fd;
    prev_dout = dout;
  end

  function automatic win_t mk(input int tl);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r*3+c] = 32'(tl + r*W + c);
    return w;
  endfunction

  scen_t tbl [3];

  task automatic run_scen(input int k, input string tag);
    scen_t s;
    s = tbl[k];
    seen.delete();
    fd_count = 0;
    for (int f = 0; f < s.frames; f++)
      for (int p = 0; p < W*H; p++) begin
        beat(32'(f*100 + p));
        idle(s.gap);
      end
    idle(3);
    check({tag, "_pulses"}, 288'(seen.size()), 288'(s.pulses));
    if (seen.size() > s.mark_idx) check({tag, "_mark_window"}, seen[s.mark_idx], s.mark_win);
    else                          check({tag, "_mark_window_missing"}, 288'(0), 288'(1));
    if (seen.size() > 0) check({tag, "_last_window"}, seen[seen.size()-1], s.last_win);
    else                 check({tag, "_last_window_missing"}, 288'(0), 288'(1));
    check({tag, "_scoreboard_drained"}, 288'(exp_q.size()), 288'(0));
`ifdef WG_FRAME_DONE_EN
    check({tag, "_frame_done_pulses"}, 288'(fd_count), 288'(s.frames));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{gap: 0, frames: 1, pulses: 4, mark_idx: 0, mark_win: mk(0),   last_win: mk(5)};
    tbl[1] = '{gap: 3, frames: 1, pulses: 4, mark_idx: 0, mark_win: mk(0),   last_win: mk(5)};
    tbl[2] = '{gap: 0, frames: 2, pulses: 8, mark_idx: 4, mark_win: mk(100), last_win: mk(105)};

    idle(2);
    check("reset_valid_out", 288'(Valid_Out), 288'(0));
    check("reset_data_out", dout, '0);
`ifdef WG_FRAME_DONE_EN
    check("reset_frame_done", 288'(Frame_Done), 288'(0));
`endif
    rst = 1'b1;
    idle(2);

    run_scen(0, "continuous");
    run_scen(1, "gapped");
    run_scen(2, "two_frames");

    // Abort a frame right after pixel 9, then restart from pixel 0.
    seen.delete();
    fd_count = 0;
    for (int p = 0; p < 10; p++) beat(32'(p));
    check("pre_reset_data_nonzero", 288'(dout != '0), 288'(1));
    rst = 1'b0;
    #1;
    check("async_reset_valid_out", 288'(Valid_Out), 288'(0));
    check("async_reset_data_out", dout, '0);
`ifdef WG_FRAME_DONE_EN
    check("async_reset_frame_done", 288'(Frame_Done), 288'(0));
    check("aborted_frame_done_pulses", 288'(fd_count), 288'(0));
`endif
    check("aborted_no_windows", 288'(seen.size()), 288'(0));
    m_row = 0;
    m_col = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    run_scen(0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
